// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift-by-N controller that drives a single-bit shifter once per clock.
module shifter16 (
  input  logic [15:0] in_data,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);
  always_comb
    sout = shift == 2'b01 ? {in_data[14:0], 1'b0} :
           shift == 2'b10 ? {1'b0, in_data[15:1]} :
           shift == 2'b11 ? {in_data[15], in_data[15:1]} :
                            in_data;
endmodule

module shift_sequencer #(
  parameter int AMT_W = 4,
  parameter bit CLAMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [15:0]      data_in,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result
);
  localparam int CW = AMT_W + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q, state_d;
  logic [15:0]   work_q, work_d, result_q, result_d, sout;
  logic [CW-1:0] cnt_q, cnt_d, amt_ext, eff;
  logic [1:0]    op_q, op_d;
  shifter16 u_shifter (.in_data(work_q), .shift(op_q), .sout(sout));
  always_comb begin
    amt_ext = CW'(amount);
    eff     = (CLAMP && amt_ext > CW'(16)) ? CW'(16) : amt_ext;
  end
  // result is loaded on the edge entering DONE so it is valid alongside the done pulse
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        work_d  = data_in;
        op_d    = op;
        cnt_d   = eff;
        state_d = (op == 2'b00 || eff == '0) ? DONE : SHIFT;
        result_d = (op == 2'b00 || eff == '0) ? data_in : result_q;
      end
      SHIFT: begin
        work_d   = sout;
        cnt_d    = cnt_q - CW'(1);
        state_d  = cnt_q == CW'(1) ? DONE : SHIFT;
        result_d = cnt_q == CW'(1) ? sout : result_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: table-driven, hand-written and random checks of shift_sequencer against a behavioural model.
module tb_shift_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start4 = 1'b0, start5 = 1'b0;
  logic [1:0] op4 = '0, op5 = '0;
  logic [3:0] amt4 = '0;
  logic [4:0] amt5 = '0;
  logic [15:0] din4 = '0, din5 = '0;
  logic busy4, done4, busy5, done5;
  logic [15:0] res4, res5;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  shift_sequencer #(.AMT_W(4), .CLAMP(1'b1)) d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .amount(amt4),
    .data_in(din4), .busy(busy4), .done(done4), .result(res4));
  shift_sequencer #(.AMT_W(5), .CLAMP(1'b1)) d5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .op(op5), .amount(amt5),
    .data_in(din5), .busy(busy5), .done(done5), .result(res5));
  typedef struct {
    int          sel;
    logic [1:0]  op;
    int          amt;
    logic [15:0] data;
    logic [15:0] exp_res;
    int          exp_lat;
    string       name;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic int eff_of(input int amt);
    return amt > 16 ? 16 : amt;
  endfunction
  function automatic logic [15:0] model(input logic [1:0] op, input int amt, input logic [15:0] d);
    logic signed [15:0] s;
    int n;
    s = d;
    n = eff_of(amt);
    case (op)
      2'b01:   return n >= 16 ? 16'h0000 : d << n;
      2'b10:   return n >= 16 ? 16'h0000 : d >> n;
      2'b11:   return s >>> (n >= 16 ? 15 : n);
      default: return d;
    endcase
  endfunction
  // caller sits at a negedge with the DUT idle; returns at the negedge after done
  task automatic run(input int sel, input logic [1:0] op, input int amt, input logic [15:0] data,
                     input logic [15:0] er, input int el, input string name);
    int lat;
    bit busy_ok;
    if (sel == 0) begin start4 = 1'b1; op4 = op; amt4 = amt[3:0]; din4 = data; end
    else begin start5 = 1'b1; op5 = op; amt5 = amt[4:0]; din5 = data; end
    lat = 0;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start4 = 1'b0; start5 = 1'b0;
        op4 = ~op4; op5 = ~op5; din4 = ~din4; din5 = ~din5; amt4 = ~amt4; amt5 = ~amt5;
      end
      if ((sel == 0 ? busy4 : busy5) !== 1'b1) busy_ok = 1'b0;
      if ((sel == 0 ? done4 : done5) === 1'b1) lat = c;
    end
    chk({name, " latency"}, lat, el);
    chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
    chk({name, " result"}, sel == 0 ? res4 : res5, er);
    @(negedge clk);
    chk({name, " idle"}, sel == 0 ? {busy4, done4} : {busy5, done5}, 2'b00);
  endtask
  initial begin
    int dones;
    vecs.push_back('{0, 2'b01, 4,  16'h0001, 16'h0010, 5,  "lsl4"});
    vecs.push_back('{0, 2'b11, 3,  16'h8000, 16'hF000, 4,  "asr3"});
    vecs.push_back('{0, 2'b10, 3,  16'h8000, 16'h1000, 4,  "lsr3"});
    vecs.push_back('{0, 2'b10, 0,  16'hBEEF, 16'hBEEF, 1,  "amt0"});
    vecs.push_back('{0, 2'b00, 9,  16'hBEEF, 16'hBEEF, 1,  "pass"});
    vecs.push_back('{0, 2'b10, 15, 16'hFFFF, 16'h0001, 16, "lsr15"});
    vecs.push_back('{0, 2'b01, 1,  16'h4001, 16'h8002, 2,  "b2b"});
    vecs.push_back('{1, 2'b11, 31, 16'h8000, 16'hFFFF, 17, "asr31"});
    vecs.push_back('{1, 2'b01, 20, 16'hFFFF, 16'h0000, 17, "lsl20"});
    vecs.push_back('{1, 2'b10, 16, 16'hFFFF, 16'h0000, 17, "lsr16"});
    vecs.push_back('{1, 2'b11, 17, 16'h7FFF, 16'h0000, 17, "asr17pos"});
    repeat (3) @(negedge clk);
    chk("reset busy", {busy4, busy5}, 2'b00);
    chk("reset done", {done4, done5}, 2'b00);
    chk("reset result", {res4, res5}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (vecs[i])
      run(vecs[i].sel, vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp_res, vecs[i].exp_lat, vecs[i].name);
    for (int i = 0; i < 60; i++) begin
      int sel, amt;
      logic [1:0] op;
      logic [15:0] d;
      sel = i % 2;
      op = 2'($urandom_range(0, 3));
      amt = sel == 0 ? $urandom_range(0, 15) : $urandom_range(0, 31);
      d = 16'($urandom);
      run(sel, op, amt, d, model(op, amt, d), (op == 2'b00) ? 1 : eff_of(amt) + 1, "rand");
    end
    start4 = 1'b1; op4 = 2'b01; amt4 = 4'd2; din4 = 16'h0003;
    @(negedge clk);
    chk("coll busy c1", {31'd0, busy4}, 32'd1);
    start4 = 1'b1; op4 = 2'b01; amt4 = 4'd2; din4 = 16'hFFFF;
    @(negedge clk);
    start4 = 1'b0;
    chk("coll done c2", {31'd0, done4}, 32'd0);
    @(negedge clk);
    chk("coll done c3", {31'd0, done4}, 32'd1);
    chk("coll result", res4, 16'h000C);
    dones = 0;
    repeat (6) begin @(negedge clk); if (done4) dones++; end
    chk("coll extra dones", dones, 0);
    start4 = 1'b1; op4 = 2'b01; amt4 = 4'd7; din4 = 16'h0001;
    repeat (3) begin @(negedge clk); start4 = 1'b0; end
    chk("rst pre busy", {31'd0, busy4}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async busy", {31'd0, busy4}, 32'd0);
    chk("rst async done", {31'd0, done4}, 32'd0);
    chk("rst async result", {res4, res5}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clk); if (done4 || busy4) dones++; end
    chk("rst no resume", dones, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
